// File: rtl/mem_access_unit.sv
// Load/store access unit: takes execute-stage load/store requests and turns
// them into word-aligned bus transfers with lane steering and a timeout abort.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        store_en,
    input  logic [31:0] load_addr,
    input  logic [1:0]  load_width,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    input  logic [1:0]  store_width,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misalign_fault,
    output logic        bus_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_reg;
    logic [7:0]  cnt_reg;
    logic [31:0] addr_reg;
    logic        we_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic [1:0]  offset_reg;
    logic        req_reg;
    logic [31:0] load_data_reg;
    logic        bus_error_reg;

    // Request selection: a store wins over a simultaneous load.
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_width;
    logic        req_misaligned;
    logic        req_accept;

    always_comb begin
        req_valid = store_en | load_en;
        req_we    = store_en;
        req_addr  = store_en ? store_addr  : load_addr;
        req_width = store_en ? store_width : load_width;
    end

    always_comb begin
        req_misaligned = 1'b0;
        case (req_width)
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b1;
        endcase
    end

    assign req_accept = (state_reg == IDLE) && req_valid && !req_misaligned;

    // Lane replication of store data so the byte enables pick the right lanes.
    logic [31:0] byte_rep;
    logic [31:0] half_rep;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_rep[gi*8 +: 8] = store_data[7:0];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_rep[gi*16 +: 16] = store_data[15:0];
        end
    endgenerate

    logic [31:0] wdata_next;
    logic [3:0]  be_next;

    always_comb begin
        wdata_next = 32'h0;
        be_next    = 4'b1111;
        if (req_we) begin
            case (req_width)
                2'b00: begin
                    wdata_next = byte_rep;
                    be_next    = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                    wdata_next = half_rep;
                    be_next    = 4'b0011 << req_addr[1:0];
                end
                default: begin
                    wdata_next = store_data;
                    be_next    = 4'b1111;
                end
            endcase
        end
    end

    logic [7:0]  cnt_inc;
    logic [31:0] rdata_aligned;

    assign cnt_inc       = cnt_reg + 8'd1;
    assign rdata_aligned = bus_rdata >> {offset_reg, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 8'd0;
            addr_reg      <= 32'h0;
            we_reg        <= 1'b0;
            wdata_reg     <= 32'h0;
            be_reg        <= 4'b0000;
            offset_reg    <= 2'b00;
            req_reg       <= 1'b0;
            load_data_reg <= 32'h0;
            bus_error_reg <= 1'b0;
        end else begin
            bus_error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_accept) begin
                        addr_reg   <= {req_addr[31:2], 2'b00};
                        we_reg     <= req_we;
                        wdata_reg  <= wdata_next;
                        be_reg     <= be_next;
                        offset_reg <= req_addr[1:0];
                        req_reg    <= 1'b1;
                        cnt_reg    <= 8'd0;
                        state_reg  <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (bus_ack) begin
                        req_reg   <= 1'b0;
                        cnt_reg   <= 8'd0;
                        if (!we_reg) begin
                            load_data_reg <= rdata_aligned;
                        end
                        state_reg <= DONE;
                    end else if (cnt_inc == TIMEOUT_LIMIT) begin
                        req_reg       <= 1'b0;
                        cnt_reg       <= 8'd0;
                        bus_error_reg <= 1'b1;
                        load_data_reg <= 32'h0;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign stall          = !rst && ((state_reg == BUSY) || req_accept);
    assign misalign_fault = !rst && (state_reg == IDLE) && req_valid && req_misaligned;
    assign bus_error      = bus_error_reg;
    assign load_data      = load_data_reg;
    assign bus_req        = req_reg;
    assign bus_we         = we_reg;
    assign bus_addr       = addr_reg;
    assign bus_wdata      = wdata_reg;
    assign bus_be         = be_reg;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max bus wait cycles before abort (1..255).
REQ-002 clk  input  1  single core clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load_en  input  1  execute stage requests a load this cycle.
REQ-005 store_en  input  1  execute stage requests a store this cycle.
REQ-006 load_addr  input  32  byte address of load.
REQ-007 load_width  input  2  00 byte, 01 halfword, 10 word (funct3[1:0]).
REQ-008 store_addr  input  32  byte address of store.
REQ-009 store_data  input  32  store data, right-aligned.
REQ-010 store_width  input  2  00 byte, 01 halfword, 10 word.
REQ-011 load_data  output  32  loaded data, right-aligned, unextended (execute performs sign extension).
REQ-012 stall  output  1  hold pipeline; execute inputs stay stable while high.
REQ-013 misalign_fault  output  1  one-cycle pulse, misaligned access rejected.
REQ-014 bus_error  output  1  one-cycle pulse, bus timeout abort.
REQ-015 bus_req  output  1  bus request, held until bus_ack.
REQ-016 bus_we  output  1  1 = write.
REQ-017 bus_addr  output  32  word-aligned address ([1:0]=00).
REQ-018 bus_wdata  output  32  lane-aligned write data.
REQ-019 bus_be  output  4  byte enables (all 1111 for reads).
REQ-020 bus_ack  input  1  bus completes transfer this cycle.
REQ-021 bus_rdata  input  32  read word, valid when bus_ack=1.

Function
REQ-022 FSM states IDLE, BUSY, DONE; registered state.
REQ-023 IDLE: store_en has priority over load_en when both high; the load is dropped.
REQ-024 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=00, or width=11; detected in IDLE, misalign_fault=1 same cycle, stall=0, no bus transaction, state stays IDLE.
REQ-025 Aligned request in IDLE: stall=1 combinationally same cycle; addr, we, wdata, be, lane offset registered; next state BUSY.
REQ-026 BUSY: bus_req=1 and bus_* outputs stable from registers; stall=1; timeout counter increments each cycle.
REQ-027 Store lanes: byte -> wdata = data[7:0] replicated into all 4 lanes, be = 0001<<addr[1:0]; half -> data[15:0] replicated twice, be = 0011<<addr[1:0]; word -> be = 1111.
REQ-028 Load alignment: load_data register <= bus_rdata >> (8*addr[1:0]) on bus_ack; upper bits above the shifted word are zero.
REQ-029 bus_ack in BUSY: bus_req deasserts next cycle; next state DONE; counter cleared.
REQ-030 Timeout: counter reaching TIMEOUT_CYCLES without ack -> bus_error=1 one cycle, load_data <= 0, next state DONE.
REQ-031 DONE: stall=0 for exactly one cycle; load_data valid; load_en/store_en ignored this cycle (they still show the completed access); next state IDLE.
REQ-032 load_data holds value until next completed load or abort; stores do not modify it.
REQ-033 Minimum latency: zero-wait-state bus (ack in first BUSY cycle) -> stall high 2 cycles, data in cycle 3.
REQ-034 bus_ack outside BUSY is ignored.

Reset
REQ-035 rst=1 at edge: state IDLE, counter 0, load_data 0, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_be 0, misalign_fault 0, bus_error 0.
REQ-036 rst in BUSY aborts transfer; bus_req low after that edge; no bus_error pulse.
REQ-037 stall is 0 while rst is high.

Verification
REQ-038 Store byte 0xA5 to 0x1003, ack first BUSY cycle -> bus_addr 0x1000, be 1000, wdata 0xA5A5A5A5, we=1, stall 2 cycles.
REQ-039 Load word 0x2000, bus_rdata 0xDEADBEEF, ack after 3 waits -> stall 5 cycles, load_data 0xDEADBEEF in DONE.
REQ-040 Load half 0x2002, rdata 0x12345678 -> load_data 0x00001234, be 1111.
REQ-041 Load word 0x2001 -> misalign_fault pulse, bus_req never high, stall 0.
REQ-042 Load with no ack, TIMEOUT_CYCLES=4 -> bus_error pulse after 4 BUSY cycles, load_data 0, then IDLE.
REQ-043 rst asserted mid-BUSY, then load_en and store_en together -> idle after reset; store issued (we=1), load dropped.
